// File: rtl/clock_bus_pkg.sv
// Shared definitions for the time databus reader: widths, source indices,
// per-source maxima and the reader FSM states.
package clock_bus_pkg;

   localparam int DW      = 6;
   localparam int NUM_SRC = 3;

   localparam int SRC_SEC = 0;
   localparam int SRC_MIN = 1;
   localparam int SRC_HR  = 2;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      CAPTURE,
      CONVERT,
      STORE,
      DONE
   } state_t;

   function automatic int src_max(input int src);
      case (src)
         SRC_SEC: return SEC_MAX;
         SRC_MIN: return MIN_MAX;
         default: return HR_MAX;
      endcase
   endfunction

endpackage

// File: rtl/time_bus_reader_if.sv
// Handshake and data signals between the time databus reader and its
// surroundings (counters on the bus side, display/date logic on the output side).
interface time_bus_reader_if #(
   parameter int DW      = clock_bus_pkg::DW,
   parameter int NUM_SRC = clock_bus_pkg::NUM_SRC
);
   logic               scan;
   logic [DW-1:0]      databus;
   logic [NUM_SRC-1:0] en;
   logic               busy;
   logic               frame_valid;
   logic [7:0]         sec_bcd;
   logic [7:0]         min_bcd;
   logic [7:0]         hour_bcd;
   logic [NUM_SRC-1:0] range_err;

   modport master (
      output scan, databus,
      input  en, busy, frame_valid, sec_bcd, min_bcd, hour_bcd, range_err
   );

   modport slave (
      input  scan, databus,
      output en, busy, frame_valid, sec_bcd, min_bcd, hour_bcd, range_err
   );
endinterface

// File: rtl/time_bus_reader_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: repeated subtract-10, one step per cycle.
// bcd stays valid after done until the next start.
module bin2bcd_seq #(
   parameter int DW = clock_bus_pkg::DW
) (
   input  logic          clk,
   input  logic          clear_n,
   input  logic          start,
   input  logic [DW-1:0] value,
   output logic          done,
   output logic [7:0]    bcd
);
   logic          active;
   logic [DW-1:0] rem;
   logic [3:0]    tens;

   assign done = active && (rem < DW'(10));
   assign bcd  = {tens, rem[3:0]};

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         active <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
      end else if (done) begin
         active <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         rem  <= value;
         tens <= '0;
      end else if (active && rem >= DW'(10)) begin
         rem  <= rem - DW'(10);
         tens <= tens + 4'd1;
      end
   end
endmodule

// File: rtl/time_bus_reader.sv
// Polls the sec/min/hour counters over the shared databus, converts each to BCD
// and publishes the whole frame atomically with per-source range flags.
module time_bus_reader
   import clock_bus_pkg::*;
#(
   parameter int DW      = clock_bus_pkg::DW,
   parameter int NUM_SRC = clock_bus_pkg::NUM_SRC
) (
   input logic              clk,
   input logic              clear_n,
   time_bus_reader_if.slave bus
);
   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   state_t             state;
   logic [IW-1:0]      idx;
   logic               pending;
   logic [DW-1:0]      raw;
   logic [7:0]         shadow [NUM_SRC];
   logic [NUM_SRC-1:0] err_shadow;

   logic               conv_start;
   logic               conv_done;
   logic [7:0]         conv_bcd;
   logic               slot_err;
   logic               last_src;
   logic [7:0]         slot_next [NUM_SRC];
   logic [NUM_SRC-1:0] err_next;

   assign conv_start = (state == CAPTURE);
   assign last_src   = (idx == IW'(NUM_SRC - 1));
   assign slot_err   = int'(raw) > src_max(int'(idx));

   // Shadow contents with the slot being stored merged in, so the last source
   // can be committed to the outputs on the same edge it is written.
   always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
         slot_next[s] = shadow[s];
         err_next[s]  = err_shadow[s];
         if (IW'(s) == idx) begin
            slot_next[s] = conv_bcd;
            err_next[s]  = slot_err;
         end
      end
   end

   bin2bcd_seq #(.DW(DW)) u_bin2bcd (
      .clk     (clk),
      .clear_n (clear_n),
      .start   (conv_start),
      .value   (bus.databus),
      .done    (conv_done),
      .bcd     (conv_bcd)
   );

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         state           <= IDLE;
         idx             <= '0;
         pending         <= 1'b0;
         bus.en          <= '0;
         bus.busy        <= 1'b0;
         bus.frame_valid <= 1'b0;
         bus.sec_bcd     <= 8'h00;
         bus.min_bcd     <= 8'h00;
         bus.hour_bcd    <= 8'h00;
         bus.range_err   <= '0;
      end else begin
         if (bus.scan && bus.busy) begin
            pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               bus.frame_valid <= 1'b0;
               if (bus.scan || pending) begin
                  state    <= DRIVE;
                  idx      <= '0;
                  bus.en   <= NUM_SRC'(1);
                  bus.busy <= 1'b1;
                  pending  <= 1'b0;
               end
            end
            DRIVE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               raw    <= bus.databus;
               bus.en <= '0;
               state  <= CONVERT;
            end
            CONVERT: begin
               if (conv_done) begin
                  state <= STORE;
               end
            end
            STORE: begin
               for (int s = 0; s < NUM_SRC; s++) begin
                  shadow[s] <= slot_next[s];
               end
               err_shadow <= err_next;
               if (last_src) begin
                  bus.sec_bcd     <= slot_next[SRC_SEC];
                  bus.min_bcd     <= slot_next[SRC_MIN];
                  bus.hour_bcd    <= slot_next[SRC_HR];
                  bus.range_err   <= err_next;
                  bus.frame_valid <= 1'b1;
                  state           <= DONE;
               end else begin
                  idx    <= idx + IW'(1);
                  bus.en <= NUM_SRC'(1) << (idx + IW'(1));
                  state  <= DRIVE;
               end
            end
            DONE: begin
               bus.frame_valid <= 1'b0;
               // A queued request restarts immediately; extra requests are dropped.
               if (pending || bus.scan) begin
                  state   <= DRIVE;
                  idx     <= '0;
                  bus.en  <= NUM_SRC'(1);
                  pending <= 1'b0;
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
